// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one DATA_W-bit word per spi_enable request, all four CPOL/CPHA modes.
// spi_done is the four-phase acknowledge returned to the request side.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// ST_IDLE  | waiting for spi_enable; sclk follows cpol, ss_n high
// ST_SETUP | ss_n low, one half-period before the first SCLK edge
// ST_XFER  | 2*DATA_W SCLK half-periods, shifting MOSI and sampling MISO
// ST_HOLD  | ss_n low, one half-period after the last SCLK edge
// ST_DONE  | spi_done raised, waiting for spi_enable to drop
module spi_shift_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              spi_clk,
    input  logic              preset,
    input  logic              spi_enable,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              ss_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_l;
    logic [CNT_W-1:0]  edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              cpol_l;
    logic              cpha_l;
    logic              half_done;

    assign half_done = (div_cnt == div_l);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge spi_clk) begin
        if (preset) begin
            state    <= ST_IDLE;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            rx_data  <= '0;
            spi_done <= 1'b0;
            div_cnt  <= '0;
            div_l    <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk     <= cpol;
                    ss_n     <= 1'b1;
                    mosi     <= 1'b0;
                    spi_done <= 1'b0;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (spi_enable) begin
                        tx_sh  <= tx_data;
                        rx_sh  <= '0;
                        cpol_l <= cpol;
                        cpha_l <= cpha;
                        div_l  <= clk_div;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    ss_n <= 1'b0;
                    sclk <= cpol_l;
                    if (!cpha_l) mosi <= tx_sh[DATA_W-1];
                    if (half_done) begin
                        div_cnt <= '0;
                        state   <= ST_XFER;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    ss_n <= 1'b0;
                    if (half_done) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        // even edge index = leading edge, odd = trailing edge
                        if (!edge_cnt[0]) begin
                            if (cpha_l) begin
                                mosi  <= tx_sh[DATA_W-1];
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end else begin
                                rx_sh <= {rx_sh[DATA_W-2:0], miso};
                            end
                        end else begin
                            if (cpha_l) begin
                                rx_sh <= {rx_sh[DATA_W-2:0], miso};
                            end else if (edge_cnt != LAST_EDGE) begin
                                mosi  <= tx_sh[DATA_W-2];
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    ss_n <= 1'b0;
                    sclk <= cpol_l;
                    if (half_done) begin
                        div_cnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ss_n <= 1'b1;
                    sclk <= cpol_l;
                    mosi <= 1'b0;
                    // first DONE cycle publishes the word; afterwards wait for the request to drop
                    if (!spi_done) begin
                        spi_done <= 1'b1;
                        rx_data  <= rx_sh;
                    end else if (!spi_enable) begin
                        spi_done <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

SPI serial engine in the `spi_clk` domain, directly downstream of the APB-to-SPI handshake synchronizer. It consumes the synchronized `spi_enable` request and shifts one `DATA_W`-bit word out on MOSI while capturing MISO. It generates SCLK and SS_n for all four CPOL/CPHA modes. It returns `spi_done` as the four-phase acknowledge that the synchronizer carries back to the APB side.

## Interface
- `DATA_W`, default 8: word length in bits, at least 2.
- `DIV_W`, default 8: width of the SCLK divider input.

Ports:
- `spi_clk` in 1: engine clock. It is the only clock in the block.
- `preset` in 1: synchronous, active-high reset.
- `spi_enable` in 1: transfer request level from the synchronizer.
- `tx_data` in DATA_W: word to transmit. It must be stable while `spi_enable` is high.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: clock phase. 0 = sample on the leading edge. 1 = sample on the trailing edge.
- `clk_div` in DIV_W: SCLK half-period, equal to `clk_div+1` spi_clk cycles.
- `miso` in 1: serial data in. It is already synchronized.
- `sclk` out 1: SPI clock, registered.
- `mosi` out 1: serial data out, MSB first, registered.
- `ss_n` out 1: slave select, active low, registered.
- `rx_data` out DATA_W: last received word.
- `spi_done` out 1: transfer-complete acknowledge.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
States: IDLE, SETUP, XFER, HOLD, DONE. Let H = `clk_div+1`.

- **Reset values:** state = IDLE, `sclk`=0, `mosi`=0, `ss_n`=1, `rx_data`=0, `spi_done`=0, `busy`=0, divider=0, bit counter=0.
- **IDLE**
  - `ss_n`=1, `spi_done`=0, `mosi`=0, and `sclk` is registered from `cpol` every cycle.
  - On `spi_enable`=1:
    - latch `tx_data` into the TX shift register;
    - latch `cpol`, `cpha` and `clk_div`;
    - clear the RX shift register;
    - go to SETUP.
- **SETUP** (H cycles)
  - `ss_n`=0 and `sclk` holds the latched `cpol`.
  - If `cpha`=0, `mosi` = TX MSB from the first SETUP cycle.
  - After H cycles, go to XFER.
- **XFER** (2·DATA_W half-periods)
  - `sclk` toggles every H cycles. There are DATA_W leading edges and DATA_W trailing edges.
  - With `cpha`=0: sample `miso` into RX LSB on each leading edge (shift left). Shift TX left and drive the next MSB on each trailing edge except the last.
  - With `cpha`=1: drive the next TX bit on each leading edge, starting with the MSB on the first. Sample `miso` on each trailing edge.
  - After the final trailing edge (`sclk` back at `cpol`), go to HOLD.
- **HOLD** (H cycles): `ss_n`=0 and `sclk`=`cpol`, then go to DONE.
- **DONE**
  - `ss_n`=1. On entry, `rx_data` is loaded from the RX shift register and `spi_done`=1.
  - Stay in DONE while `spi_enable`=1.
  - Return to IDLE on the cycle after `spi_enable`=0 is sampled; `spi_done` clears on that same transition.
- **Divider:** counts 0..`clk_div` and wraps. It restarts at 0 on every state entry. `clk_div`=0 gives H=1, which is the maximum rate of SCLK = spi_clk/2.
- **Configuration:** `tx_data`, `cpol`, `cpha` and `clk_div` are ignored outside IDLE. Mid-transfer changes have no effect.

## Timing
- **Latency:** `spi_done` rises exactly (2·DATA_W+2)·H + 1 `spi_clk` edges after the edge that samples `spi_enable`=1 in IDLE. For DATA_W=8 and `clk_div`=1 this is 37 edges.
- **Handshake:** four-phase.
  - A new transfer starts only from IDLE, which requires `spi_enable` to have been low with `spi_done` low.
  - `spi_enable` held high after DONE does not start a second transfer.
- **`spi_enable` deasserted mid-transfer:** ignored. The transfer completes and DONE is entered. `spi_done` is then high for exactly one cycle before the return to IDLE.
- **`preset` mid-transfer:** all outputs take their reset values on the next edge, including `ss_n`=1 and `sclk`=0. The partial `rx_data` is discarded.
- **`preset` priority:** `preset` overrides a simultaneous `spi_enable` rise.
- **Output registers:** `rx_data` changes only on DONE entry. `mosi`, `sclk` and `ss_n` never glitch because they are driven straight from flops.

## Test plan
- **Mode 0 loopback:** `cpol`=0, `cpha`=0, `clk_div`=1, `tx_data`=0xA5, `miso` tied to `mosi` → 8 rising `sclk` edges, `rx_data`=0xA5, `spi_done` at edge 37, `ss_n` low for 36 cycles.
- **Mode 3:** `cpol`=1, `cpha`=1, `clk_div`=0, `tx_data`=0x3C, `miso` driven 0xC3 by a bench slave model sampling/driving per mode 3 → `sclk` idles high, `mosi` bit stream 0,0,1,1,1,1,0,0, `rx_data`=0xC3, `spi_done` at edge 19.
- **Modes 1 and 2:** `cpol`=0,`cpha`=1 and `cpol`=1,`cpha`=0 with `tx_data`=0x81 → sample points land on trailing and leading edges respectively, and `rx_data`=0x81 in loopback.
- **Handshake:** hold `spi_enable` high for 10 cycles after `spi_done` → no second transfer, `ss_n` stays 1. Drop `spi_enable` → `spi_done` low next cycle. Re-raise `spi_enable` with `tx_data`=0x5A → second transfer completes with `rx_data`=0x5A.
- **Early drop:** lower `spi_enable` after 3 bits → full 8-bit transfer still completes, and `spi_done` is a 1-cycle pulse.
- **Reset mid-transfer:** assert `preset` for 1 cycle during bit 4 → next edge has `ss_n`=1, `sclk`=0, `busy`=0, `rx_data`=0. A fresh transfer after the reset completes normally.
